// File: rtl/mycpu_pipe_ctrl.sv
// Pipeline control for the MIPS core: shadow valid/dest tracking, load-use interlock, forwarding, freezes, flushes.
// Build option: define MYCPU_PIPE_FWD_EN for operand forwarding; without it every RAW hazard interlocks.
module mycpu_pipe_ctrl #(
  parameter int NSTAGE   = 5,
  parameter int LOAD_RDY = NSTAGE - 1,
  parameter int REG_AW   = 5,
  parameter int SW       = $clog2(NSTAGE + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic              d_use_rs,
  input  logic              d_use_rt,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_regwrite,
  input  logic              d_load,
  input  logic              i_wait,
  input  logic              d_wait,
  input  logic              redirect,
  output logic              en_f,
  output logic              en_d,
  output logic              bubble_e,
  output logic              en_back,
  output logic [SW-1:0]     fwd_rs_e,
  output logic [SW-1:0]     fwd_rt_e,
  output logic [NSTAGE-1:0] stage_valid,
  output logic              ld_stall
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              load;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              useRs;
    logic              useRt;
  } entry_t;

  if (NSTAGE < 5 || NSTAGE > 8 || LOAD_RDY < 3 || LOAD_RDY > NSTAGE - 1) begin : gBadParams
    $error("mycpu_pipe_ctrl: NSTAGE must be 5..8 and LOAD_RDY 3..NSTAGE-1");
  end

  // shadow[NSTAGE] is the retired slot: the instruction that left W last cycle
  entry_t shadow [2:NSTAGE];
  entry_t eNext;
  logic   hazard;

  function automatic logic writesReg(entry_t e, logic [REG_AW-1:0] r);
    return e.valid && e.regwrite && (e.rd == r) && (r != '0);
  endfunction

  always_comb begin
    logic inWindow;
    logic srcHit;
    hazard   = 1'b0;
    inWindow = 1'b0;
    srcHit   = 1'b0;
    for (int s = 2; s <= NSTAGE; s++) begin
`ifdef MYCPU_PIPE_FWD_EN
      inWindow = shadow[s].load && (s + 1 < LOAD_RDY);
`else
      // once a producer has retired its regfile write is visible, so only 2..W block
      inWindow = (s < NSTAGE);
`endif
      srcHit = (d_use_rs && writesReg(shadow[s], d_rs)) ||
               (d_use_rt && writesReg(shadow[s], d_rt));
      if (inWindow && srcHit) hazard = 1'b1;
    end
  end

  assign ld_stall = !resetn && d_valid && hazard;

  // d_wait freezes everything; redirect flushes D and E even over an interlock
  always_comb begin
    en_f     = 1'b0;
    en_d     = 1'b0;
    bubble_e = 1'b1;
    en_back  = 1'b0;
    if (!resetn) begin
      if (d_wait) begin
        bubble_e = 1'b0;
      end else if (redirect) begin
        en_f    = 1'b1;
        en_d    = 1'b1;
        en_back = 1'b1;
      end else if (ld_stall || i_wait) begin
        en_back = 1'b1;
      end else begin
        en_f     = 1'b1;
        en_d     = 1'b1;
        bubble_e = 1'b0;
        en_back  = 1'b1;
      end
    end
  end

  always_comb begin
    eNext = '0;
    if (!bubble_e) begin
      eNext.valid    = d_valid;
      eNext.rd       = d_rd;
      eNext.regwrite = d_regwrite;
      eNext.load     = d_load;
      eNext.rs       = d_rs;
      eNext.rt       = d_rt;
      eNext.useRs    = d_use_rs;
      eNext.useRt    = d_use_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int s = 2; s <= NSTAGE; s++) shadow[s] <= '0;
    end else if (en_back) begin
      shadow[2] <= eNext;
      for (int s = 3; s <= NSTAGE; s++) shadow[s] <= shadow[s-1];
    end
  end

`ifdef MYCPU_PIPE_FWD_EN
  // scan oldest to youngest so the youngest matching producer wins
  always_comb begin
    fwd_rs_e = '0;
    fwd_rt_e = '0;
    if (!resetn && shadow[2].valid) begin
      for (int s = NSTAGE; s >= 3; s--) begin
        if (shadow[2].useRs && writesReg(shadow[s], shadow[2].rs)) fwd_rs_e = SW'(s);
        if (shadow[2].useRt && writesReg(shadow[s], shadow[2].rt)) fwd_rt_e = SW'(s);
      end
    end
  end
`else
  assign fwd_rs_e = '0;
  assign fwd_rt_e = '0;
`endif

  always_comb begin
    stage_valid    = '0;
    stage_valid[0] = !i_wait;
    stage_valid[1] = d_valid;
    for (int s = 2; s < NSTAGE; s++) stage_valid[s] = !resetn && shadow[s].valid;
  end

endmodule

// File: tb/tb_mycpu_pipe_ctrl.sv
// Bench for mycpu_pipe_ctrl: directed vector table plus randomized traffic against a queue-based pipeline model.
// Expectations follow the MYCPU_PIPE_FWD_EN setting of the build.
module tb_mycpu_pipe_ctrl;
  localparam int NS  = 5;
  localparam int LR  = 4;
  localparam int AW  = 5;
  localparam int SWB = $clog2(NS + 1);

  logic           clk = 1'b0;
  logic           resetn;
  logic           d_valid, d_use_rs, d_use_rt, d_regwrite, d_load;
  logic [AW-1:0]  d_rs, d_rt, d_rd;
  logic           i_wait, d_wait, redirect;
  logic           en_f, en_d, bubble_e, en_back, ld_stall;
  logic [SWB-1:0] fwd_rs_e, fwd_rt_e;
  logic [NS-1:0]  stage_valid;

  mycpu_pipe_ctrl #(.NSTAGE(NS), .LOAD_RDY(LR), .REG_AW(AW), .SW(SWB)) dut (
    .clk(clk), .resetn(resetn), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_rd(d_rd), .d_regwrite(d_regwrite),
    .d_load(d_load), .i_wait(i_wait), .d_wait(d_wait), .redirect(redirect),
    .en_f(en_f), .en_d(en_d), .bubble_e(bubble_e), .en_back(en_back),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .stage_valid(stage_valid), .ld_stall(ld_stall)
  );

  always #5 clk = ~clk;

  typedef struct { bit rst, dv; int rs, rt; bit urs, urt; int rd; bit rw, ld, iw, dw, rdr; } in_t;
  typedef struct { bit ef, ed, bub, eb; int frs, frt; bit stl; } out_t;
  typedef struct { in_t i; out_t o; } vec_t;
  typedef struct { bit v; int rd; bit rw, ld; int rs, rt; bit urs, urt; } ment_t;

  vec_t  tbl[$];
  ment_t mq[$];   // mq[0] = E, mq[k] = stage k+2, last element = retired slot
  int    nCmp = 0;
  int    nFail = 0;
  int    stepNo = 0;

  function automatic in_t mkIns(int rs, int rt, bit urs, bit urt, int rd, bit rw, bit ld);
    in_t x = '{default: 0};
    x.dv = 1; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt; x.rd = rd; x.rw = rw; x.ld = ld;
    return x;
  endfunction

  function automatic in_t mkNop();
    in_t x = '{default: 0};
    return x;
  endfunction

  function automatic in_t ctl(in_t b, bit rst, bit iw, bit dw, bit rdr);
    in_t x = b;
    x.rst = rst; x.iw = iw; x.dw = dw; x.rdr = rdr;
    return x;
  endfunction

  function automatic out_t mkOut(bit ef, bit ed, bit bub, bit eb, int frs, int frt, bit stl);
    out_t o;
    o.ef = ef; o.ed = ed; o.bub = bub; o.eb = eb; o.frs = frs; o.frt = frt; o.stl = stl;
    return o;
  endfunction

  task automatic add(input in_t x, input out_t o);
    vec_t v;
    v.i = x; v.o = o;
    tbl.push_back(v);
  endtask

  function automatic bit wr(ment_t e, int r);
    return e.v && e.rw && e.rd == r && r != 0;
  endfunction

  function automatic int firstProducer(bit used, int r);
    if (!used) return 0;
    for (int i = 1; i < mq.size(); i++)
      if (wr(mq[i], r)) return i + 2;
    return 0;
  endfunction

  function automatic void modelOut(input in_t x, output out_t o, output logic [NS-1:0] sv);
    bit hz = 0;
    o = '{default: 0};
    for (int i = 0; i < mq.size(); i++) begin
      int stg = i + 2;
      bit needs = (x.urs && wr(mq[i], x.rs)) || (x.urt && wr(mq[i], x.rt));
`ifdef MYCPU_PIPE_FWD_EN
      if (needs && mq[i].ld && stg + 1 < LR) hz = 1;
`else
      if (needs && stg < NS) hz = 1;
`endif
    end
    o.stl = !x.rst && x.dv && hz;
    if (x.rst)           begin o.ef = 0; o.ed = 0; o.bub = 1; o.eb = 0; end
    else if (x.dw)       begin o.ef = 0; o.ed = 0; o.bub = 0; o.eb = 0; end
    else if (x.rdr)      begin o.ef = 1; o.ed = 1; o.bub = 1; o.eb = 1; end
    else if (o.stl || x.iw) begin o.ef = 0; o.ed = 0; o.bub = 1; o.eb = 1; end
    else                 begin o.ef = 1; o.ed = 1; o.bub = 0; o.eb = 1; end
`ifdef MYCPU_PIPE_FWD_EN
    if (!x.rst && mq[0].v) begin
      o.frs = firstProducer(mq[0].urs, mq[0].rs);
      o.frt = firstProducer(mq[0].urt, mq[0].rt);
    end
`endif
    sv = '0;
    sv[0] = !x.iw;
    sv[1] = x.dv;
    if (!x.rst)
      for (int i = 0; i < NS - 2; i++) sv[i+2] = mq[i].v;
  endfunction

  task automatic modelStep(input in_t x, input out_t o);
    ment_t n = '{default: 0};
    if (x.rst) begin
      foreach (mq[i]) mq[i].v = 0;
    end else if (o.eb) begin
      if (!o.bub) begin
        n.v = x.dv; n.rd = x.rd; n.rw = x.rw; n.ld = x.ld;
        n.rs = x.rs; n.rt = x.rt; n.urs = x.urs; n.urt = x.urt;
      end
      mq.push_front(n);
      void'(mq.pop_back());
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", nm, stepNo, got, exp);
    end
  endtask

  task automatic cmpOut(input string tag, input out_t e);
    cmp({tag, ".en_f"},     32'(en_f),     32'(e.ef));
    cmp({tag, ".en_d"},     32'(en_d),     32'(e.ed));
    cmp({tag, ".bubble_e"}, 32'(bubble_e), 32'(e.bub));
    cmp({tag, ".en_back"},  32'(en_back),  32'(e.eb));
    cmp({tag, ".fwd_rs_e"}, 32'(fwd_rs_e), e.frs);
    cmp({tag, ".fwd_rt_e"}, 32'(fwd_rt_e), e.frt);
    cmp({tag, ".ld_stall"}, 32'(ld_stall), 32'(e.stl));
  endtask

  task automatic drive(input in_t x);
    resetn     = x.rst;
    d_valid    = x.dv;
    d_rs       = AW'(x.rs);
    d_rt       = AW'(x.rt);
    d_use_rs   = x.urs;
    d_use_rt   = x.urt;
    d_rd       = AW'(x.rd);
    d_regwrite = x.rw;
    d_load     = x.ld;
    i_wait     = x.iw;
    d_wait     = x.dw;
    redirect   = x.rdr;
  endtask

  task automatic runStep(input in_t x, input bit hand, input out_t he);
    out_t          mo;
    logic [NS-1:0] msv;
    @(negedge clk);
    drive(x);
    #2;
    modelOut(x, mo, msv);
    if (hand) cmpOut("vec", he);
    else      cmpOut("rnd", mo);
    cmp("stage_valid", 32'(stage_valid), 32'(msv));
    @(posedge clk);
    modelStep(x, mo);
    stepNo++;
  endtask

  task automatic buildTable();
    out_t rstO = mkOut(0, 0, 1, 0, 0, 0, 0);
    out_t run  = mkOut(1, 1, 0, 1, 0, 0, 0);
    out_t stl  = mkOut(0, 0, 1, 1, 0, 0, 1);
    out_t frz  = mkOut(0, 0, 0, 0, 0, 0, 1);
`ifdef MYCPU_PIPE_FWD_EN
    add(ctl(mkIns(1, 2, 1, 1, 3, 1, 0), 1, 0, 0, 0), rstO);
    add(mkIns(1, 2, 1, 1, 3, 1, 0), run);                       // addu $3
    add(mkIns(3, 5, 1, 1, 6, 1, 0), run);                       // back-to-back use, no stall
    add(mkIns(7, 0, 1, 0, 4, 1, 1), mkOut(1, 1, 0, 1, 3, 0, 0)); // consumer in E: fwd 3
    add(mkIns(4, 9, 1, 1, 8, 1, 0), stl);                       // lw $4 in E -> interlock
    add(mkIns(4, 9, 1, 1, 8, 1, 0), run);
    add(mkNop(), mkOut(1, 1, 0, 1, 4, 0, 0));                   // fwd from stage 4
    add(mkIns(1, 1, 1, 1, 0, 1, 1), run);                       // lw $0
    add(mkIns(0, 0, 1, 1, 10, 1, 0), run);                      // read $0: no stall
    add(mkNop(), run);                                          // $0 never forwarded
    add(mkIns(7, 0, 1, 0, 5, 1, 1), run);                       // lw $5
    for (int k = 0; k < 3; k++) add(ctl(mkIns(5, 10, 1, 1, 11, 1, 0), 0, 0, 1, 0), frz);
    add(mkIns(5, 10, 1, 1, 11, 1, 0), stl);
    add(mkIns(5, 10, 1, 1, 11, 1, 0), run);
    add(mkNop(), mkOut(1, 1, 0, 1, 4, 0, 0));
    add(mkIns(7, 0, 1, 0, 12, 1, 1), run);                      // lw $12
    add(ctl(mkIns(12, 0, 1, 0, 13, 1, 0), 0, 0, 0, 1), mkOut(1, 1, 1, 1, 0, 0, 1));
    add(ctl(mkNop(), 0, 1, 0, 0), mkOut(0, 0, 1, 1, 0, 0, 0));  // i_wait
    add(mkIns(1, 2, 1, 1, 14, 1, 0), run);
    add(mkNop(), run);
    add(mkNop(), run);
    add(mkIns(14, 14, 1, 1, 15, 1, 0), run);
    add(mkNop(), mkOut(1, 1, 0, 1, 5, 5, 0));                   // retired-slot forward
    add(mkIns(7, 0, 1, 0, 2, 1, 1), run);
    add(ctl(mkIns(2, 0, 1, 0, 3, 1, 0), 1, 0, 0, 0), rstO);     // reset kills pending interlock
    add(mkIns(2, 0, 1, 0, 3, 1, 0), run);
`else
    add(ctl(mkIns(1, 2, 1, 1, 3, 1, 0), 1, 0, 0, 0), rstO);
    add(mkIns(1, 2, 1, 1, 3, 1, 0), run);
    for (int k = 0; k < 3; k++) add(mkIns(3, 5, 1, 1, 6, 1, 0), stl);  // $3 in E, M, W
    add(mkIns(3, 5, 1, 1, 6, 1, 0), run);                       // producer retired
    add(mkIns(6, 6, 0, 0, 0, 1, 0), run);                       // unused sources never stall
    add(mkIns(0, 0, 1, 1, 8, 1, 0), run);                       // $0 producer ignored
    for (int k = 0; k < 3; k++) add(ctl(mkIns(8, 1, 1, 0, 9, 1, 0), 0, 0, 1, 0), frz);
    for (int k = 0; k < 3; k++) add(mkIns(8, 1, 1, 0, 9, 1, 0), stl);
    add(mkIns(8, 1, 1, 0, 9, 1, 0), run);
    add(ctl(mkIns(9, 0, 1, 0, 10, 1, 0), 0, 0, 0, 1), mkOut(1, 1, 1, 1, 0, 0, 1));
    add(ctl(mkNop(), 0, 1, 0, 0), mkOut(0, 0, 1, 1, 0, 0, 0));
    add(ctl(mkIns(9, 0, 1, 0, 10, 1, 0), 1, 0, 0, 0), rstO);
    add(mkIns(9, 0, 1, 0, 10, 1, 0), run);
`endif
  endtask

  function automatic in_t randIn();
    in_t x = '{default: 0};
    x.rst = ($urandom_range(0, 99) < 2);
    x.dv  = ($urandom_range(0, 9) < 8);
    x.rs  = $urandom_range(0, 3);
    x.rt  = $urandom_range(0, 3);
    x.urs = ($urandom_range(0, 3) != 0);
    x.urt = ($urandom_range(0, 3) != 0);
    x.rd  = $urandom_range(0, 3);
    x.rw  = ($urandom_range(0, 9) < 7);
    x.ld  = ($urandom_range(0, 99) < 35);
    x.iw  = ($urandom_range(0, 9) == 0);
    x.dw  = ($urandom_range(0, 99) < 12);
    x.rdr = ($urandom_range(0, 99) < 8);
    return x;
  endfunction

  initial begin
    out_t dummy = '{default: 0};
    for (int i = 0; i < NS - 1; i++) mq.push_back('{default: 0});
    drive(ctl(mkNop(), 1, 0, 0, 0));
    buildTable();
    foreach (tbl[k]) runStep(tbl[k].i, 1'b1, tbl[k].o);
    for (int k = 0; k < 2000; k++) runStep(randIn(), 1'b0, dummy);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
